req_ack_sequencer: RTL and testbench

Shared-resource handshake sequencer that arbitrates N requesters onto one acknowledging resource. It enforces the req/grant/ack timing contract: grant one cycle after req, then ack within a bounded window. Protocol violations are reported as error pulses. It sits between requester ports and the shared target, and its outputs are the signals that the team's temporal-delay SVA properties check.

---
 rtl/req_ack_sequencer_pkg.sv | 29 ++
 rtl/req_ack_sequencer_if.sv | 28 ++
 rtl/req_ack_sequencer_rr_pick.sv | 34 +++
 rtl/req_ack_sequencer.sv | 111 +++++++++++
 tb/tb_req_ack_sequencer.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/req_ack_sequencer_pkg.sv
// Shared types and sizing helpers for the req/ack handshake sequencer.
package req_ack_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // Value at which the grant-age counter stops counting.
    function automatic int cnt_sat(input int ack_min, input int ack_max);
        return (ack_max == 0) ? ack_min : ack_max + 1;
    endfunction

    // With an unbounded window the counter only needs to reach ACK_MIN.
    function automatic int cnt_width(input int ack_min, input int ack_max);
        int sat;
        sat = cnt_sat(ack_min, ack_max);
        return (sat < 1) ? 1 : $clog2(sat + 1);
    endfunction

    function automatic int id_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEFAULT_N_REQ = 4;
    localparam int GRANT_ID_W    = id_width(DEFAULT_N_REQ);

endpackage

// File: rtl/req_ack_sequencer_if.sv
// Requester/resource handshake bundle; slave is the sequencer, master the driving side.
interface req_ack_sequencer_if #(
    parameter int N_REQ = 4
);
    import req_ack_pkg::*;

    localparam int GID_W = id_width(N_REQ);

    logic [N_REQ-1:0] req;
    logic             ack;
    logic [N_REQ-1:0] grant;
    logic [GID_W-1:0] grant_id;
    logic             busy;
    logic             err_early;
    logic             err_timeout;
    logic             err_stray;

    modport master (
        output req, ack,
        input  grant, grant_id, busy, err_early, err_timeout, err_stray
    );

    modport slave (
        input  req, ack,
        output grant, grant_id, busy, err_early, err_timeout, err_stray
    );

endinterface

// File: rtl/req_ack_sequencer_rr_pick.sv
// Combinational round-robin picker: first requester strictly after ptr_i, wrapping.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  pick_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    localparam int unsigned NU = N;

    always_comb begin
        int unsigned   i;
        logic [IW-1:0] cand;
        pick_o  = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        i       = 0;
        cand    = '0;
        for (int unsigned off = 1; off <= NU; off++) begin
            i    = (32'(ptr_i) + off) % NU;
            cand = IW'(i);
            if (!valid_o && req_i[cand]) begin
                valid_o      = 1'b1;
                pick_o[cand] = 1'b1;
                idx_o        = cand;
            end
        end
    end

endmodule

// File: rtl/req_ack_sequencer.sv
// Arbitrates N requesters onto one acking resource and flags req/grant/ack timing violations.
module req_ack_sequencer
    import req_ack_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int ACK_MIN = 2,
    parameter int ACK_MAX = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    req_ack_sequencer_if.slave bus
);

    localparam int GID_W = id_width(N_REQ);
    localparam int CW    = cnt_width(ACK_MIN, ACK_MAX);
    localparam int SAT   = cnt_sat(ACK_MIN, ACK_MAX);

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [GID_W-1:0]   gid_q, gid_d;
    logic [GID_W-1:0]   ptr_q, ptr_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic               early_q, early_d;
    logic               tmo_q, tmo_d;
    logic               stray_q, stray_d;

    logic [N_REQ-1:0]   pick;
    logic [GID_W-1:0]   pick_idx;
    logic               pick_valid;

    rr_pick #(.N(N_REQ), .IW(GID_W)) u_pick (
        .req_i   (bus.req),
        .ptr_i   (ptr_q),
        .pick_o  (pick),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gid_d   = gid_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        early_d = 1'b0;
        tmo_d   = 1'b0;
        stray_d = bus.ack && (state_q != GRANT);
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = GRANT;
                    cnt_d   = '0;
                    gid_d   = pick_idx;
                    grant_d = pick;
                end
            end
            GRANT: begin
                if (int'(cnt_q) != SAT) cnt_d = cnt_q + 1'b1;
                // ack outranks both timeout and a same-cycle request drop
                if (bus.ack) begin
                    early_d = (int'(cnt_q) < ACK_MIN);
                    state_d = RELEASE;
                end else if ((ACK_MAX != 0) && (int'(cnt_q) == ACK_MAX)) begin
                    tmo_d   = 1'b1;
                    state_d = RELEASE;
                end else if (!bus.req[gid_q]) begin
                    state_d = RELEASE;
                end
                if (state_d == RELEASE) grant_d = '0;
            end
            RELEASE: begin
                ptr_d   = gid_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gid_q   <= '0;
            ptr_q   <= GID_W'(N_REQ - 1);
            grant_q <= '0;
            early_q <= 1'b0;
            tmo_q   <= 1'b0;
            stray_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gid_q   <= gid_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            early_q <= early_d;
            tmo_q   <= tmo_d;
            stray_q <= stray_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_id    = gid_q;
    assign bus.busy        = (state_q == GRANT);
    assign bus.err_early   = early_q;
    assign bus.err_timeout = tmo_q;
    assign bus.err_stray   = stray_q;

endmodule

// File: tb/tb_req_ack_sequencer.sv
// Scoreboard bench for req_ack_sequencer: randomized transactions against a round-robin reference.
module tb_req_ack_sequencer;
    import req_ack_pkg::*;

    localparam int N    = 4;
    localparam int AMIN = 2;
    localparam int AMAX = 5;

    localparam int K_ACCEPT  = 0;
    localparam int K_EARLY   = 1;
    localparam int K_TIMEOUT = 2;
    localparam int K_CANCEL  = 3;

    typedef struct {
        int id;
        int len;
        bit early;
        bit tmo;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst0_n = 1'b0;
    always #5 clk = ~clk;

    req_ack_sequencer_if #(.N_REQ(N)) bus ();
    req_ack_sequencer #(.N_REQ(N), .ACK_MIN(AMIN), .ACK_MAX(AMAX)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    req_ack_sequencer_if #(.N_REQ(N)) bus0 ();
    req_ack_sequencer #(.N_REQ(N), .ACK_MIN(2), .ACK_MAX(0)) dut0 (
        .clk(clk), .rst_n(rst0_n), .bus(bus0)
    );

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   mptr = N - 1;
    bit   done0 = 1'b0;
    exp_t expq[$];
    int   stray_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int rr_ref(input logic [N-1:0] p, input int ptr);
        for (int k = 1; k <= N; k++) begin
            if (p[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    // Call in an IDLE cycle (after posedge #1); returns in an IDLE cycle.
    task automatic txn(input logic [N-1:0] pat, input int kind, input int e, input int gap,
                       input bit stray_rel, input bit stray_idle);
        exp_t x;
        x.id    = rr_ref(pat, mptr);
        x.len   = (kind == K_TIMEOUT) ? AMAX + 1 : e + 1;
        x.early = (kind == K_EARLY);
        x.tmo   = (kind == K_TIMEOUT);
        expq.push_back(x);
        mptr = x.id;
        bus.req = pat;
        @(posedge clk); #1;
        repeat ((kind == K_TIMEOUT) ? AMAX : e) begin @(posedge clk); #1; end
        if (kind == K_ACCEPT || kind == K_EARLY) bus.ack = 1'b1;
        else if (kind == K_CANCEL) bus.req = '0;
        @(posedge clk); #1;
        bus.req = '0;
        bus.ack = stray_rel;
        if (stray_rel) stray_q.push_back(cyc + 1);
        @(posedge clk); #1;
        bus.ack = 1'b0;
        for (int g = 0; g < gap; g++) begin
            if (stray_idle && g == 0) begin
                bus.ack = 1'b1;
                stray_q.push_back(cyc + 1);
            end
            @(posedge clk); #1;
            bus.ack = 1'b0;
        end
    endtask

    bit active = 1'b0;
    bit seen = 1'b0;
    int cur_id = 0;
    int cur_len = 0;
    int gap_len = 0;
    int last_id = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_grant", bus.grant, 0);
            check("rst_busy", bus.busy, 0);
            check("rst_gid", bus.grant_id, 0);
            check("rst_err", {bus.err_early, bus.err_timeout, bus.err_stray}, 0);
            active  = 1'b0;
            seen    = 1'b0;
            last_id = 0;
        end else begin
            if (stray_q.size() > 0 && stray_q[0] == cyc) begin
                check("err_stray", bus.err_stray, 1);
                void'(stray_q.pop_front());
            end else begin
                check("no_stray", bus.err_stray, 0);
            end
            if (bus.grant != '0) begin
                if (!active) begin
                    active  = 1'b1;
                    cur_len = 0;
                    for (int i = N - 1; i >= 0; i--) if (bus.grant[i]) cur_id = i;
                    if (seen) check("dead_cycles", gap_len >= 2, 1);
                end
                cur_len++;
                check("onehot", $countones(bus.grant), 1);
                check("busy_hi", bus.busy, 1);
                check("gid_match", bus.grant_id, cur_id);
                check("err_in_grant", {bus.err_early, bus.err_timeout}, 0);
                if (cur_len > 60) begin
                    $display("FAIL grant_stuck: grant held %0d cycles, limit 60", cur_len);
                    errors++;
                    $fatal(1, "grant stuck");
                end
            end else begin
                check("busy_lo", bus.busy, 0);
                if (active) begin
                    active  = 1'b0;
                    seen    = 1'b1;
                    gap_len = 1;
                    check("pending_txn", expq.size(), 1);
                    if (expq.size() > 0) begin
                        exp_t x;
                        x = expq.pop_front();
                        check("grantee", cur_id, x.id);
                        check("grant_len", cur_len, x.len);
                        check("err_early", bus.err_early, x.early);
                        check("err_timeout", bus.err_timeout, x.tmo);
                        last_id = x.id;
                    end
                end else begin
                    gap_len++;
                    check("err_idle", {bus.err_early, bus.err_timeout}, 0);
                    check("gid_hold", bus.grant_id, last_id);
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time exceeded, limit 600000");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    // Unbounded-window instance: late ack accepted, early ack still flagged.
    initial begin
        bus0.req = '0;
        bus0.ack = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst0_n = 1'b1;
        @(posedge clk); #1;
        bus0.req = 4'b1000;
        @(posedge clk); #1;
        for (int c = 0; c < 40; c++) begin
            check("u0_grant_held", bus0.grant, 4'b1000);
            check("u0_no_timeout", bus0.err_timeout, 0);
            @(posedge clk); #1;
        end
        bus0.ack = 1'b1;
        @(posedge clk); #1;
        bus0.ack = 1'b0;
        bus0.req = '0;
        check("u0_release", bus0.grant, 0);
        check("u0_late_ok", {bus0.err_early, bus0.err_timeout, bus0.err_stray}, 0);
        @(posedge clk); #1;
        bus0.req = 4'b0001;
        @(posedge clk); #1;
        check("u0_grant0", bus0.grant, 4'b0001);
        @(posedge clk); #1;
        bus0.ack = 1'b1;
        @(posedge clk); #1;
        bus0.ack = 1'b0;
        bus0.req = '0;
        check("u0_early", bus0.err_early, 1);
        check("u0_early_drop", bus0.grant, 0);
        done0 = 1'b1;
    end

    initial begin
        int kind, e;
        bus.req = '0;
        bus.ack = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int t = 0; t < 5; t++) txn(4'b1111, K_ACCEPT, 2, 0, 1'b0, 1'b0);
        txn(4'b0010, K_ACCEPT, 3, 2, 1'b0, 1'b0);
        txn(4'b0110, K_EARLY, 1, 1, 1'b0, 1'b0);
        txn(4'b0110, K_ACCEPT, 2, 1, 1'b0, 1'b0);
        txn(4'b0001, K_TIMEOUT, 0, 2, 1'b1, 1'b1);
        txn(4'b1000, K_CANCEL, 2, 1, 1'b0, 1'b1);
        txn(4'b0100, K_ACCEPT, 5, 0, 1'b0, 1'b0);

        for (int t = 0; t < 250; t++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                K_ACCEPT: e = $urandom_range(AMIN, AMAX);
                K_EARLY:  e = $urandom_range(0, AMIN - 1);
                K_CANCEL: e = $urandom_range(0, AMAX - 1);
                default:  e = AMAX;
            endcase
            txn(N'($urandom_range(1, 15)), kind, e, $urandom_range(0, 3),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        bus.req = 4'b0001;
        @(posedge clk); #1;
        repeat (3) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        check("async_grant", bus.grant, 0);
        check("async_busy", bus.busy, 0);
        check("async_err", {bus.err_early, bus.err_timeout, bus.err_stray}, 0);
        bus.req = '0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        mptr = N - 1;
        txn(4'b0100, K_ACCEPT, 3, 2, 1'b0, 1'b0);

        repeat (4) @(posedge clk);
        for (int i = 0; i < 200 && !done0; i++) @(posedge clk);
        check("u0_finished", done0, 1);
        check("exp_drained", expq.size(), 0);
        check("stray_drained", stray_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
